wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter WORD_LEN, default 16: datapath width in bits.
REQ-002 Parameter REG_ADDR_LEN, default 3: register-file address width.
REQ-003 Parameter N_SRC, default 4: number of write-back sources, minimum 2; SEL_W = max(1, clog2(N_SRC)).
REQ-004 Parameter MEM_IDX, default 2: index of the source that comes from data memory and needs mem_valid.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  upstream holds a retiring instruction.
REQ-008 in_ready  out  1  stage accepts in_valid this cycle.
REQ-009 in_sel  in  SEL_W  source index for the retiring instruction.
REQ-010 in_rd  in  REG_ADDR_LEN  destination register.
REQ-011 in_we  in  1  instruction writes the register file.
REQ-012 src_data  in  N_SRC*WORD_LEN  flattened sources; source k is bits [k*WORD_LEN +: WORD_LEN].
REQ-013 mem_valid  in  1  data-memory word on source MEM_IDX is valid.
REQ-014 flush  in  1  discards the pending instruction.
REQ-015 rf_we / rf_waddr / rf_wdata  out  1 / REG_ADDR_LEN / WORD_LEN  register-file write port, registered.
REQ-016 sel_err  out  1  one-cycle pulse on an out-of-range selection.

Function
REQ-017 FSM states: IDLE and WAIT_MEM; in_ready = 1 in IDLE, 0 in WAIT_MEM.
REQ-018 Accept in IDLE when in_valid=1 and flush=0; in_sel, in_rd and in_we are captured.
REQ-019 Non-memory select, or memory select with mem_valid=1 in the accept cycle: write issued the next cycle (latency 1).
REQ-020 Memory select with mem_valid=0: go to WAIT_MEM and hold the captured fields.
REQ-021 In WAIT_MEM, the first cycle with mem_valid=1 samples src_data[MEM_IDX], issues the write the next cycle and returns to IDLE.
REQ-022 Write data is the selected source word sampled in the cycle of completion.
REQ-023 rf_we = in_we AND (rd != 0) AND select legal; register 0 is never written.
REQ-024 in_sel >= N_SRC: no write, sel_err = 1 for exactly one cycle after accept, FSM stays in IDLE.
REQ-025 rf_we is a one-cycle pulse; rf_waddr and rf_wdata hold their last values while rf_we = 0.
REQ-026 flush in WAIT_MEM returns to IDLE without a write; flush in IDLE blocks acceptance that cycle.
REQ-027 flush together with mem_valid in WAIT_MEM: flush wins and no write occurs.
REQ-028 Back-to-back accepts in IDLE produce one write per cycle with no bubble.

Reset
REQ-029 rst returns the FSM to IDLE and clears rf_we, rf_waddr, rf_wdata, sel_err and all captured fields to 0, immediately and asynchronously.
REQ-030 A reset asserted during WAIT_MEM drops the pending write; no write is issued after rst deasserts.

Configuration
REQ-031 Macro WB_FWD_EN, when defined, adds outputs fwd_valid (1), fwd_rd (REG_ADDR_LEN) and fwd_data (WORD_LEN).
REQ-032 These outputs are combinational copies of the write about to be registered, so a write is visible one cycle before rf_we rises; fwd_valid=0 in WAIT_MEM until mem_valid.
REQ-033 Without WB_FWD_EN the ports and their logic are absent; all other behaviour is identical.

Structure
REQ-034 The shared package holds the FSM state typedef, the WORD_LEN and REG_ADDR_LEN defaults, and the source indices SEL_TGT_NPC=0, SEL_TGT_ALU=1, SEL_TGT_MEM=2.
REQ-035 One sub-module, wb_src_mux: parametrised N_SRC-to-1 selection that also outputs a legal flag.

Verification
REQ-036 ALU write: in_sel=1, rd=3, we=1, source1=0x1234 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x1234.
REQ-037 Memory wait: in_sel=2, mem_valid held 0 for 3 cycles then 1 with data 0xBEEF -> in_ready=0 for 3 cycles, rf_wdata=0xBEEF one cycle after mem_valid.
REQ-038 Register 0 and illegal select: rd=0, we=1 -> rf_we=0; with N_SRC=3, in_sel=3 -> sel_err pulse, no write.
REQ-039 Flush in WAIT_MEM with mem_valid=1 in the same cycle -> no write, in_ready=1 the next cycle.
REQ-040 rst asserted mid-WAIT_MEM -> all outputs 0 immediately, no write after release; with WB_FWD_EN, fwd_data=0x00AA one cycle before rf_wdata=0x00AA.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared types and constants for the write-back stage
package wb_stage_pkg;
    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

    localparam int WORD_LEN_DEF     = 16;
    localparam int REG_ADDR_LEN_DEF = 3;

    localparam int SEL_TGT_NPC = 0;
    localparam int SEL_TGT_ALU = 1;
    localparam int SEL_TGT_MEM = 2;
endpackage

// File: rtl/wb_src_mux.sv
// wb_src_mux: N_SRC-to-1 word select with a legal-index flag
module wb_src_mux #(
    parameter int N_SRC    = 4,
    parameter int WORD_LEN = 16,
    parameter int SEL_W    = 2
) (
    input  logic [SEL_W-1:0]          i_sel,
    input  logic [N_SRC*WORD_LEN-1:0] i_data,
    output logic [WORD_LEN-1:0]       o_data,
    output logic                      o_legal
);
    // pick the addressed source; indices at or beyond N_SRC read as zero and flag illegal
    always_comb begin
        o_data  = '0;
        o_legal = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_data  = i_data[k*WORD_LEN +: WORD_LEN];
                o_legal = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: register-file write-back with memory wait; WB_FWD_EN adds forwarding outputs
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int WORD_LEN     = WORD_LEN_DEF,
    parameter int REG_ADDR_LEN = REG_ADDR_LEN_DEF,
    parameter int N_SRC        = 4,
    parameter int MEM_IDX      = SEL_TGT_MEM,
    parameter int SEL_W        = (N_SRC > 2) ? $clog2(N_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic [REG_ADDR_LEN-1:0]   in_rd,
    input  logic                      in_we,
    input  logic [N_SRC*WORD_LEN-1:0] src_data,
    input  logic                      mem_valid,
    input  logic                      flush,
    output logic                      rf_we,
    output logic [REG_ADDR_LEN-1:0]   rf_waddr,
    output logic [WORD_LEN-1:0]       rf_wdata,
    output logic                      sel_err
`ifdef WB_FWD_EN
    ,
    output logic                      fwd_valid,
    output logic [REG_ADDR_LEN-1:0]   fwd_rd,
    output logic [WORD_LEN-1:0]       fwd_data
`endif
);
    localparam logic [SEL_W-1:0] MEM_SEL = SEL_W'(MEM_IDX);

    wb_state_t               r_state;
    logic [SEL_W-1:0]        r_sel;
    logic [REG_ADDR_LEN-1:0] r_rd;
    logic                    r_we;
    logic                    r_rf_we;
    logic [REG_ADDR_LEN-1:0] r_rf_waddr;
    logic [WORD_LEN-1:0]     r_rf_wdata;
    logic                    r_sel_err;

    logic                    w_wait;
    logic [SEL_W-1:0]        w_sel;
    logic [REG_ADDR_LEN-1:0] w_rd;
    logic                    w_we;
    logic [WORD_LEN-1:0]     w_data;
    logic                    w_legal;
    logic                    w_accept;
    logic                    w_is_mem;
    logic                    w_done;
    logic                    w_write;

    assign w_wait   = (r_state == WAIT_MEM);
    assign w_sel    = w_wait ? r_sel : in_sel;
    assign w_rd     = w_wait ? r_rd  : in_rd;
    assign w_we     = w_wait ? r_we  : in_we;
    assign w_accept = !w_wait && in_valid && !flush;
    assign w_is_mem = (w_sel == MEM_SEL);
    // an instruction completes when accepted without a memory dependency, or when memory arrives unflushed
    assign w_done   = w_wait ? (mem_valid && !flush) : (w_accept && (!w_is_mem || mem_valid));
    assign w_write  = w_done && w_legal && w_we && (w_rd != '0);
    assign in_ready = !w_wait;

    wb_src_mux #(
        .N_SRC   (N_SRC),
        .WORD_LEN(WORD_LEN),
        .SEL_W   (SEL_W)
    ) u_mux (
        .i_sel  (w_sel),
        .i_data (src_data),
        .o_data (w_data),
        .o_legal(w_legal)
    );

    // FSM: park in WAIT_MEM only for a legal memory select whose data is not ready yet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_rd    <= '0;
            r_we    <= 1'b0;
        end else if (w_wait) begin
            r_state <= (flush || mem_valid) ? IDLE : WAIT_MEM;
        end else if (w_accept) begin
            r_sel   <= in_sel;
            r_rd    <= in_rd;
            r_we    <= in_we;
            r_state <= (w_legal && w_is_mem && !mem_valid) ? WAIT_MEM : IDLE;
        end
    end

    // registered write port pulses for one cycle; address and data hold between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_sel_err  <= 1'b0;
        end else begin
            r_rf_we   <= w_write;
            r_sel_err <= w_accept && !w_legal;
            if (w_write) begin
                r_rf_waddr <= w_rd;
                r_rf_wdata <= w_data;
            end
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;
    assign sel_err  = r_sel_err;

`ifdef WB_FWD_EN
    assign fwd_valid = w_write;
    assign fwd_rd    = w_rd;
    assign fwd_data  = w_data;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage (N_SRC=3 so an illegal select exists); honours WB_FWD_EN
module tb_wb_stage;
    typedef struct {
        logic        we;
        logic        err;
        logic [2:0]  a;
        logic [15:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_sel = '0;
    logic [2:0]  in_rd = '0;
    logic        in_we = 1'b0;
    logic [47:0] src_data = '0;
    logic        mem_valid = 1'b0;
    logic        flush = 1'b0;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        sel_err;
`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [2:0]  fwd_rd;
    logic [15:0] fwd_data;
`endif

    int n_chk = 0;
    int n_fail = 0;
    exp_t exp_q[$];

    bit          pend = 0;
    logic [2:0]  p_rd = '0;
    logic        p_we = 1'b0;
    logic [2:0]  last_a = '0;
    logic [15:0] last_d = '0;

    wb_stage #(.WORD_LEN(16), .REG_ADDR_LEN(3), .N_SRC(3), .MEM_IDX(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_rd    (in_rd),
        .in_we    (in_we),
        .src_data (src_data),
        .mem_valid(mem_valid),
        .flush    (flush),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .sel_err  (sel_err)
`ifdef WB_FWD_EN
        ,
        .fwd_valid(fwd_valid),
        .fwd_rd   (fwd_rd),
        .fwd_data (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, req, $time);
        end
    endtask

    // one stimulus cycle: drive, then let the reference model predict what the next edge must produce
    task automatic cyc(input logic v, input logic [1:0] s, input logic [2:0] rd, input logic we,
                       input logic mv, input logic fl, input logic r,
                       input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
        exp_t e;
        logic w;
        logic [2:0] wa;
        logic [15:0] wd;
        @(negedge clk);
        rst = r; in_valid = v; in_sel = s; in_rd = rd; in_we = we;
        mem_valid = mv; flush = fl; src_data = {d2, d1, d0};
        #1;
        w = 1'b0; wa = '0; wd = '0;
        e = '{we: 1'b0, err: 1'b0, a: last_a, d: last_d};
        if (r) begin
            pend = 0; last_a = '0; last_d = '0;
            e = '{we: 1'b0, err: 1'b0, a: 3'd0, d: 16'd0};
            chk("rst_rf_we", rf_we, 0);
            chk("rst_waddr", rf_waddr, 0);
            chk("rst_wdata", rf_wdata, 0);
            chk("rst_sel_err", sel_err, 0);
            chk("rst_ready", in_ready, 1);
        end else begin
            chk("in_ready", in_ready, !pend);
            if (pend) begin
                if (fl) pend = 0;
                else if (mv) begin
                    pend = 0; w = p_we && p_rd != 0; wa = p_rd; wd = d2;
                end
            end else if (v && !fl) begin
                if (s >= 3) e.err = 1'b1;
                else if (s == 2 && !mv) begin
                    pend = 1; p_rd = rd; p_we = we;
                end else begin
                    w = we && rd != 0; wa = rd;
                    wd = (s == 0) ? d0 : (s == 1) ? d1 : d2;
                end
            end
            if (w) begin
                last_a = wa; last_d = wd;
                e.we = 1'b1; e.a = wa; e.d = wd;
            end
        end
`ifdef WB_FWD_EN
        chk("fwd_valid", fwd_valid, w);
        if (w) begin
            chk("fwd_rd", fwd_rd, wa);
            chk("fwd_data", fwd_data, wd);
        end
`endif
        exp_q.push_back(e);
    endtask

    // monitor: after every rising edge compare the registered outputs with the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_we", rf_we, e.we);
                chk("sel_err", sel_err, e.err);
                chk("rf_waddr", rf_waddr, e.a);
                chk("rf_wdata", rf_wdata, e.d);
            end
        end
    end

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("async_rst_we", rf_we, 0);
        chk("async_rst_ready", in_ready, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        // ALU write
        cyc(1, 1, 3, 1, 0, 0, 0, 16'h1111, 16'h1234, 16'h2222);
        @(posedge clk); #1;
        chk("alu_we", rf_we, 1);
        chk("alu_addr", rf_waddr, 3);
        chk("alu_data", rf_wdata, 16'h1234);
        // memory wait then data arrives
        cyc(1, 2, 5, 1, 0, 0, 0, 16'h1, 16'h2, 16'h3);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 16'h4, 16'h5, 16'h6);
        cyc(0, 0, 0, 0, 1, 0, 0, 16'h7, 16'h8, 16'hBEEF);
        @(posedge clk); #1;
        chk("mem_we", rf_we, 1);
        chk("mem_data", rf_wdata, 16'hBEEF);
        // register 0, then illegal select
        cyc(1, 1, 0, 1, 0, 0, 0, 16'h9, 16'hA, 16'hB);
        cyc(1, 3, 4, 1, 0, 0, 0, 16'hC, 16'hD, 16'hE);
        @(posedge clk); #1;
        chk("illegal_err", sel_err, 1);
        chk("illegal_we", rf_we, 0);
        // flush with mem_valid in WAIT_MEM, then ready again
        cyc(1, 2, 6, 1, 0, 0, 0, 16'h0, 16'h0, 16'h5A5A);
        cyc(0, 0, 0, 0, 1, 1, 0, 16'h0, 16'h0, 16'hA5A5);
        cyc(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        // flush in IDLE blocks acceptance
        cyc(1, 1, 7, 1, 0, 1, 0, 16'h0, 16'hDEAD, 16'h0);
        // reset mid WAIT_MEM drops the pending write
        cyc(1, 2, 2, 1, 0, 0, 0, 16'h0, 16'h0, 16'h1);
        cyc(0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0, 16'h2);
        cyc(0, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0, 16'h3);
        // forwarded write of 0x00AA, then back-to-back writes
        cyc(1, 0, 1, 1, 0, 0, 0, 16'h00AA, 16'h0, 16'h0);
        for (int i = 0; i < 4; i++)
            cyc(1, 1, 3'(i + 1), 1, 0, 0, 0, 16'h0, 16'(16'h100 + i), 16'h0);
        // randomized traffic
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 3'($urandom), 1'($urandom),
                $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0,
                16'($urandom), 16'($urandom), 16'($urandom));
        cyc(0, 0, 0, 0, 0, 1, 0, 16'h0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
